ib_mem_loader: RTL and testbench

Upstream loader for the matrix-mult buffer memories (input, weight, output-preload). It accepts a narrow element stream (one WIDTH-bit element per handshake) and packs LANES consecutive elements into one memory word. It then writes consecutive words into a buffer memory through the external memory-control path (cenb/wenb/addr/data, all active-low strobes), starting at a programmed base address. Its memory outputs are selected onto the buffer while `ext_en_i` is high, so the array's buffers are filled before `start_i` is issued to the multiplier.

---
 rtl/ib_mem_loader_if.sv | 24 ++
 rtl/ib_mem_loader.sv | 96 +++++++++
 tb/tb_ib_mem_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ib_mem_loader_if.sv
// ib_mem_loader_if: element stream plus buffer-memory write bus; master is the loader side.
interface ib_mem_loader_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int SIZE  = 256
);
    localparam int AW = $clog2(SIZE);
    localparam int DW = WIDTH * LANES;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             mem_cenb;
    logic             mem_wenb;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_data;
    modport master (
        input  s_valid, s_data,
        output s_ready, mem_cenb, mem_wenb, mem_addr, mem_data
    );
    modport slave (
        output s_valid, s_data,
        input  s_ready, mem_cenb, mem_wenb, mem_addr, mem_data
    );
endinterface

// File: rtl/ib_mem_loader.sv
// ib_mem_loader: packs LANES stream elements per word and writes consecutive words from a base address.
module ib_mem_loader #(
    parameter  int WIDTH = 8,
    parameter  int LANES = 4,
    parameter  int SIZE  = 256,
    localparam int AW    = $clog2(SIZE),
    localparam int DW    = WIDTH * LANES,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic [AW-1:0]        base_addr_i,
    input  logic [AW:0]          num_words_i,
    ib_mem_loader_if.master      bus,
    output logic                 busy_o,
    output logic                 done_o
);
    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    state_t        state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   num_q, num_d;
    logic [DW-1:0] pack_q, pack_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            num_q      <= '0;
            pack_q     <= '0;
            wr_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            pack_q     <= pack_d;
            wr_q       <= wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        pack_d     = pack_q;
        wr_d       = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = (num_words_i == '0) ? DONE : FILL;
                addr_d  = base_addr_i;
                num_d   = num_words_i;
                cnt_d   = '0;
                lane_d  = '0;
            end
            FILL: if (bus.s_valid) begin
                pack_d[lane_q*WIDTH +: WIDTH] = bus.s_data;
                lane_d = lane_q + 1'b1;
                // word complete: latch it for next-cycle write while lane 0 of the next word may already arrive
                if (lane_q == LAST_LANE) begin
                    lane_d     = '0;
                    wr_d       = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = pack_d;
                    addr_d     = addr_q + 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = (cnt_q + 1'b1 == num_q) ? FLUSH : FILL;
                end
            end
            FLUSH: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.s_ready  = (state_q == FILL);
    assign bus.mem_cenb = ~wr_q;
    assign bus.mem_wenb = ~wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign busy_o       = (state_q == FILL) || (state_q == FLUSH);
    assign done_o       = (state_q == DONE);
endmodule

// File: tb/tb_ib_mem_loader.sv
// tb_ib_mem_loader: randomized loads checked against a word-list model of the packing and address rules.
module tb_ib_mem_loader;
    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int SIZE  = 256;
    localparam int AW    = $clog2(SIZE);
    localparam int NW    = AW + 1;
    localparam int DW    = WIDTH * LANES;
    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [NW-1:0] num_words_i = '0;
    logic          busy_o, done_o;
    ib_mem_loader_if #(.WIDTH(WIDTH), .LANES(LANES), .SIZE(SIZE)) bus();
    ib_mem_loader #(.WIDTH(WIDTH), .LANES(LANES), .SIZE(SIZE)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .num_words_i (num_words_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );
    always #5 clk_i = ~clk_i;
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk_i) cyc <= cyc + 1;
    int               acc_c[$];
    int               wr_c[$];
    logic [AW-1:0]    wr_a[$];
    logic [DW-1:0]    wr_d[$];
    logic             wr_we[$];
    int               done_c[$];
    logic             busy_h [0:65535];
    logic             ready_h[0:65535];
    logic [WIDTH-1:0] stim[$];
    int               sidx;
    // passive monitor: everything observed mid-cycle, indexed by cycle number
    always @(negedge clk_i) begin
        busy_h[cyc & 16'hFFFF]  = busy_o;
        ready_h[cyc & 16'hFFFF] = bus.s_ready;
        if (bus.s_valid && bus.s_ready) acc_c.push_back(cyc);
        if (!bus.mem_cenb) begin
            wr_c.push_back(cyc);
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_data);
            wr_we.push_back(bus.mem_wenb);
        end
        if (done_o) done_c.push_back(cyc);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic clear_mon();
        acc_c.delete(); wr_c.delete(); wr_a.delete(); wr_d.delete(); wr_we.delete(); done_c.delete();
    endtask
    task automatic pulse_start(input int base, input int num, output int c0);
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        num_words_i = NW'(num);
        c0          = cyc;
        @(posedge clk_i); #1;
        start_i     = 1'b0;
    endtask
    // bubble: percent of idle cycles; negative means valid toggles every other cycle
    task automatic feed(input int count, input int bubble);
        int   got = 0;
        int   guard = 0;
        logic took;
        logic tog = 1'b1;
        while (got < count && guard < count * 20 + 50) begin
            bus.s_valid = (bubble < 0) ? tog : ($urandom_range(99) >= bubble);
            bus.s_data  = stim[sidx];
            tog = ~tog;
            @(negedge clk_i);
            took = bus.s_valid && bus.s_ready;
            @(posedge clk_i); #1;
            if (took) begin
                sidx++;
                got++;
            end
            guard++;
        end
        bus.s_valid = 1'b0;
        check("feed_count", got, count);
    endtask
    task automatic run_load(input int base, input int num, input int bubble, input bit seq, input bit ign);
        int            c0, cx, t, lim;
        logic [DW-1:0] exp_d;
        logic          rh;
        stim.delete();
        sidx = 0;
        for (int i = 0; i < num * LANES; i++) stim.push_back(seq ? WIDTH'(i + 1) : WIDTH'($urandom));
        clear_mon();
        pulse_start(base, num, c0);
        if (num == 0) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'h5A;
            repeat (6) begin @(posedge clk_i); #1; end
            bus.s_valid = 1'b0;
            rh = 1'b0;
            for (int c = c0; c <= c0 + 6; c++) rh |= ready_h[c];
            check("zero_done_cyc", (done_c.size() == 1) ? done_c[0] : -1, c0 + 1);
            check("zero_busy", busy_h[c0 + 1], 1'b0);
            check("zero_no_write", wr_c.size(), 0);
            check("zero_no_ready", rh, 1'b0);
            check("zero_no_accept", acc_c.size(), 0);
            return;
        end
        if (ign) begin
            feed(LANES + 1, bubble);
            pulse_start(100, 1, cx);
            feed(num * LANES - LANES - 1, bubble);
        end else begin
            feed(num * LANES, bubble);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        for (int g = 0; g < 40 && done_c.size() == 0; g++) begin @(posedge clk_i); #1; end
        bus.s_valid = 1'b0;
        check("accept_count", acc_c.size(), num * LANES);
        check("write_count", wr_c.size(), num);
        lim = (wr_c.size() < num) ? wr_c.size() : num;
        for (int i = 0; i < lim; i++) begin
            exp_d = '0;
            for (int k = 0; k < LANES; k++) exp_d |= DW'(stim[i * LANES + k]) << (k * WIDTH);
            check("wr_addr", wr_a[i], (base + i) % SIZE);
            check("wr_data", wr_d[i], exp_d);
            check("wr_wenb", wr_we[i], 1'b0);
            if (acc_c.size() > i * LANES + LANES - 1)
                check("wr_latency", wr_c[i], acc_c[i * LANES + LANES - 1] + 1);
        end
        if (seq && bubble == 0 && lim >= 2) begin
            check("contig_w0", wr_d[0], 32'h04030201);
            check("contig_w1", wr_d[1], 32'h08070605);
            check("contig_spacing", wr_c[1] - wr_c[0], LANES);
        end
        t = (wr_c.size() > 0) ? wr_c[wr_c.size() - 1] : c0;
        check("done_count", done_c.size(), 1);
        check("done_cyc", (done_c.size() > 0) ? done_c[0] : -1, t + 1);
        check("start_busy", busy_h[c0 + 1], 1'b1);
        check("start_ready", ready_h[c0 + 1], 1'b1);
        check("last_ready", ready_h[t], 1'b0);
        check("last_busy", busy_h[t], 1'b1);
        check("done_busy", busy_h[t + 1], 1'b0);
        check("hold_addr", bus.mem_addr, (base + num - 1) % SIZE);
        check("idle_cenb", bus.mem_cenb, 1'b1);
    endtask
    initial begin
        int c0, base, num;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", bus.s_ready, 1'b0);
        check("rst_cenb", bus.mem_cenb, 1'b1);
        check("rst_wenb", bus.mem_wenb, 1'b1);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_data", bus.mem_data, 0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        run_load(5, 2, 0, 1'b1, 1'b0);
        run_load(255, 2, 0, 1'b0, 1'b0);
        run_load(5, 2, -1, 1'b1, 1'b0);
        run_load(17, 0, 0, 1'b0, 1'b0);
        run_load(40, 3, 0, 1'b0, 1'b1);
        // reset after 2 of 4 elements: partial word is discarded
        stim.delete();
        sidx = 0;
        for (int i = 0; i < LANES; i++) stim.push_back(WIDTH'($urandom));
        pulse_start(7, 1, c0);
        feed(2, 0);
        rstn_i = 1'b0;
        @(posedge clk_i); #1;
        check("mid_rst_ready", bus.s_ready, 1'b0);
        check("mid_rst_cenb", bus.mem_cenb, 1'b1);
        check("mid_rst_wenb", bus.mem_wenb, 1'b1);
        check("mid_rst_addr", bus.mem_addr, 0);
        check("mid_rst_data", bus.mem_data, 0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        rstn_i = 1'b1;
        clear_mon();
        repeat (8) begin @(posedge clk_i); #1; end
        check("mid_rst_no_write", wr_c.size(), 0);
        check("mid_rst_no_done", done_c.size(), 0);
        run_load(9, 1, 0, 1'b0, 1'b0);
        // reset sampled on the same edge that accepts the last lane: strobe must not appear
        stim.delete();
        sidx = 0;
        for (int i = 0; i < LANES; i++) stim.push_back(WIDTH'($urandom));
        pulse_start(20, 1, c0);
        feed(LANES - 1, 0);
        bus.s_valid = 1'b1;
        bus.s_data  = stim[LANES - 1];
        rstn_i      = 1'b0;
        clear_mon();
        @(posedge clk_i); #1;
        rstn_i      = 1'b1;
        bus.s_valid = 1'b0;
        check("rst_edge_cenb", bus.mem_cenb, 1'b1);
        repeat (6) begin @(posedge clk_i); #1; end
        check("rst_edge_no_write", wr_c.size(), 0);
        check("rst_edge_no_done", done_c.size(), 0);
        for (int r = 0; r < 10; r++) begin
            base = $urandom_range(SIZE - 1);
            num  = $urandom_range(1, 6);
            run_load(base, num, $urandom_range(0, 60), 1'b0, (num >= 2) && ($urandom_range(1) == 1));
        end
        run_load(3, SIZE, 10, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
